// File: rtl/cus43_tile_shifter.sv
// cus43_tile_shifter
//
// Per-layer tile pixel serializer. Captures the tile attribute byte from
// video SRAM and a 4-pixel graphics word from the tile PROMs. Emits one 3-bit
// pixel per CLK_6M together with its palette bank, honouring screen flip.
// A fine-scroll delay line aligns the stream to the screen before it goes to
// the layer priority mixer.
//
// Parameters
//   TRANSPARENT_PEN  pen value treated as transparent
//   DELAY_DEPTH      number of delay-line stages (>= 8 so every FINE value maps)
//
// Ports
//   CLK_6M    in   pixel clock, all state on rising edge
//   nRST      in   asynchronous active-low reset
//   FLIP      in   screen flip, latched with each group at S3H
//   S3H       in   group load strobe (one cycle per 4 pixels)
//   ATTR_LD   in   capture RD into the pending attribute
//   RD        in   [7:0] tile attribute (palette bank)
//   GD        in   [11:0] graphics word, GD[11:9] = leftmost unflipped pixel
//   FINE      in   [2:0] fine-scroll delay select
//   LAYER_EN  in   layer enable
//   PIX       out  [2:0] pixel pen
//   COLOR     out  [7:0] palette bank for PIX
//   OPAQUE    out  pixel is not transparent and layer enabled
//   UNDERRUN  out  sticky: shifter ran dry while enabled

module cus43_tile_shifter #(
    parameter logic [2:0] TRANSPARENT_PEN = 3'd7,
    parameter int         DELAY_DEPTH     = 8
) (
    input  logic       CLK_6M,
    input  logic       nRST,
    input  logic       FLIP,
    input  logic       S3H,
    input  logic       ATTR_LD,
    input  logic [7:0] RD,
    input  logic [11:0] GD,
    input  logic [2:0] FINE,
    input  logic       LAYER_EN,
    output logic [2:0] PIX,
    output logic [7:0] COLOR,
    output logic       OPAQUE,
    output logic       UNDERRUN
);

    typedef struct packed {
        logic [2:0] pix;
        logic [7:0] color;
        logic       opaque;
    } tap_t;

    localparam tap_t TAP_IDLE = '{pix: TRANSPARENT_PEN, color: 8'h00, opaque: 1'b0};

    logic [7:0]  pending;
    logic [7:0]  active;
    logic [11:0] gd_q;
    logic        flip_q;
    logic [2:0]  count;
    logic [2:0]  fine_q;
    logic        underrun_q;
    tap_t        d [DELAY_DEPTH];

    logic        has_pix;
    logic [2:0]  head;
    tap_t        emit;

    // The raw PROM word is kept as loaded; the latched flip decides which end
    // is the head and which way it shifts, so FLIP only matters at S3H.
    assign has_pix = (count != 3'd0);
    assign head    = flip_q ? gd_q[2:0] : gd_q[11:9];

    always_comb begin
        emit = '{pix: TRANSPARENT_PEN, color: active, opaque: 1'b0};
        if (has_pix && LAYER_EN) begin
            emit.pix    = head;
            emit.opaque = (head != TRANSPARENT_PEN);
        end
    end

    // Attribute path. A same-cycle ATTR_LD bypasses pending so the new
    // attribute goes straight to the group being loaded.
    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            pending <= 8'h00;
            active  <= 8'h00;
        end else begin
            if (ATTR_LD) begin
                pending <= RD;
            end
            if (S3H) begin
                active <= ATTR_LD ? RD : pending;
            end
        end
    end

    // Pixel shifter. Emission (into d[0]) uses the contents before this
    // edge's load, so a reload every 4 clocks produces a gapless stream and
    // an early reload simply drops what was left.
    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            gd_q   <= 12'h000;
            flip_q <= 1'b0;
            count  <= 3'd0;
        end else if (S3H) begin
            gd_q   <= GD;
            flip_q <= FLIP;
            count  <= 3'd4;
        end else if (has_pix) begin
            gd_q  <= flip_q ? (gd_q >> 3) : (gd_q << 3);
            count <= count - 3'd1;
        end
    end

    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            underrun_q <= 1'b0;
        end else if (!has_pix && LAYER_EN) begin
            underrun_q <= 1'b1;
        end
    end

    // Delay line. The attribute travels with each pixel so COLOR changes
    // exactly on group boundaries at any FINE setting.
    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DELAY_DEPTH; i++) begin
                d[i] <= TAP_IDLE;
            end
        end else begin
            d[0] <= emit;
            for (int i = 1; i < DELAY_DEPTH; i++) begin
                d[i] <= d[i-1];
            end
        end
    end

    // FINE is registered so the output tap mux is driven only by flops.
    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            fine_q <= 3'd0;
        end else begin
            fine_q <= FINE;
        end
    end

    assign PIX      = d[fine_q].pix;
    assign COLOR    = d[fine_q].color;
    assign OPAQUE   = d[fine_q].opaque;
    assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_cus43_tile_shifter.sv
module tb_cus43_tile_shifter;

    logic        CLK_6M = 1'b0;
    logic        nRST = 1'b0;
    logic        FLIP = 1'b0;
    logic        S3H = 1'b0;
    logic        ATTR_LD = 1'b0;
    logic [7:0]  RD = 8'h00;
    logic [11:0] GD = 12'h000;
    logic [2:0]  FINE = 3'd0;
    logic        LAYER_EN = 1'b0;
    logic [2:0]  PIX;
    logic [7:0]  COLOR;
    logic        OPAQUE;
    logic        UNDERRUN;

    int total = 0;
    int bad = 0;

    cus43_tile_shifter #(.TRANSPARENT_PEN(3'd7), .DELAY_DEPTH(8)) dut (
        .CLK_6M(CLK_6M), .nRST(nRST), .FLIP(FLIP), .S3H(S3H), .ATTR_LD(ATTR_LD),
        .RD(RD), .GD(GD), .FINE(FINE), .LAYER_EN(LAYER_EN), .PIX(PIX),
        .COLOR(COLOR), .OPAQUE(OPAQUE), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK_6M = ~CLK_6M;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK_6M);
        #1;
    endtask

    task automatic do_reset();
        S3H = 0; ATTR_LD = 0; FLIP = 0; LAYER_EN = 0; RD = 8'h00; GD = 12'h000; FINE = 3'd0;
        @(posedge CLK_6M);
        #2 nRST = 0;
        #4 nRST = 1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (PIX !== 3'd7) begin bad++; $display("FAIL reset_pix got=%0d want=7", PIX); end
        total++; if (COLOR !== 8'h00) begin bad++; $display("FAIL reset_color got=%h want=00", COLOR); end
        total++; if (OPAQUE !== 1'b0) begin bad++; $display("FAIL reset_opaque got=%b want=0", OPAQUE); end
        total++; if (UNDERRUN !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", UNDERRUN); end
    endtask

    // flip_at_load selects order; FLIP is dropped right after the load edge
    task automatic single_group(input logic flip_at_load, input string tag);
        do_reset();
        RD = 8'h5A; ATTR_LD = 1; step();
        ATTR_LD = 0; S3H = 1; GD = 12'o0123; FLIP = flip_at_load; step();
        S3H = 0; LAYER_EN = 1; FLIP = ~flip_at_load;
        for (int n = 0; n < 4; n++) begin
            logic [2:0] want;
            want = flip_at_load ? 3'(3 - n) : 3'(n);
            step();
            total++; if (PIX !== want) begin bad++; $display("FAIL %s_pix%0d got=%0d want=%0d", tag, n, PIX, want); end
            total++; if (COLOR !== 8'h5A || OPAQUE !== 1'b1 || UNDERRUN !== 1'b0) begin
                bad++; $display("FAIL %s_attr%0d got color=%h opq=%b und=%b want 5a/1/0", tag, n, COLOR, OPAQUE, UNDERRUN);
            end
        end
        step();
        total++; if (UNDERRUN !== 1'b1 || PIX !== 3'd7 || OPAQUE !== 1'b0) begin
            bad++; $display("FAIL %s_dry got und=%b pix=%0d opq=%b want 1/7/0", tag, UNDERRUN, PIX, OPAQUE);
        end
        FLIP = 0; LAYER_EN = 0;
    endtask

    task automatic test_basic();
        single_group(1'b0, "basic");
    endtask

    task automatic test_flip();
        single_group(1'b1, "flip");
    endtask

    task automatic test_back_to_back();
        do_reset();
        RD = 8'h11; ATTR_LD = 1; step();
        ATTR_LD = 0; S3H = 1; GD = 12'o7654; step();
        S3H = 0; LAYER_EN = 1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] want_pix;
            logic [7:0] want_col;
            ATTR_LD = (i == 0); RD = 8'h22;
            S3H = (i == 3); GD = 12'o3210;
            step();
            want_pix = 3'(7 - i);
            want_col = (i < 4) ? 8'h11 : 8'h22;
            total++; if (PIX !== want_pix || COLOR !== want_col || OPAQUE !== (want_pix != 3'd7)) begin
                bad++; $display("FAIL b2b_%0d got pix=%0d col=%h opq=%b want %0d/%h/%b", i, PIX, COLOR, OPAQUE, want_pix, want_col, want_pix != 3'd7);
            end
            total++; if (UNDERRUN !== 1'b0) begin bad++; $display("FAIL b2b_und%0d got=%b want=0", i, UNDERRUN); end
        end
        ATTR_LD = 0; S3H = 0; LAYER_EN = 0;
    endtask

    task automatic test_fine();
        do_reset();
        FINE = 3'd5;
        RD = 8'h5A; ATTR_LD = 1; step();
        ATTR_LD = 0; S3H = 1; GD = 12'o0123; step();
        S3H = 0; LAYER_EN = 1;
        step(); step(); step();
        S3H = 1; GD = 12'o4567; step();
        S3H = 0; step();
        total++; if (PIX !== 3'd7) begin bad++; $display("FAIL fine_pre got=%0d want=7", PIX); end
        step();
        total++; if (PIX !== 3'd0 || COLOR !== 8'h5A) begin bad++; $display("FAIL fine_first got pix=%0d col=%h want 0/5a", PIX, COLOR); end
        FINE = 3'd0; step();
        total++; if (PIX !== 3'd6 || OPAQUE !== 1'b1 || COLOR !== 8'h5A) begin
            bad++; $display("FAIL fine_jump got pix=%0d opq=%b col=%h want 6/1/5a", PIX, OPAQUE, COLOR);
        end
        step();
        total++; if (PIX !== 3'd7 || OPAQUE !== 1'b0 || UNDERRUN !== 1'b0) begin
            bad++; $display("FAIL fine_last got pix=%0d opq=%b und=%b want 7/0/0", PIX, OPAQUE, UNDERRUN);
        end
        step();
        total++; if (UNDERRUN !== 1'b1) begin bad++; $display("FAIL fine_dry got=%b want=1", UNDERRUN); end
        LAYER_EN = 0; FINE = 3'd0;
    endtask

    task automatic test_bypass_disable();
        do_reset();
        RD = 8'h11; ATTR_LD = 1; step();
        RD = 8'hC3; ATTR_LD = 1; S3H = 1; GD = 12'o0123; step();
        ATTR_LD = 0; S3H = 0; LAYER_EN = 1;
        step();
        total++; if (COLOR !== 8'hC3 || PIX !== 3'd0) begin bad++; $display("FAIL bypass got col=%h pix=%0d want c3/0", COLOR, PIX); end
        step(); step(); step();
        total++; if (COLOR !== 8'hC3 || PIX !== 3'd3) begin bad++; $display("FAIL bypass_end got col=%h pix=%0d want c3/3", COLOR, PIX); end
        LAYER_EN = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (PIX !== 3'd7 || OPAQUE !== 1'b0 || UNDERRUN !== 1'b0) begin
                bad++; $display("FAIL disabled_%0d got pix=%0d opq=%b und=%b want 7/0/0", i, PIX, OPAQUE, UNDERRUN);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        LAYER_EN = 1; step();
        total++; if (UNDERRUN !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b want=1", UNDERRUN); end
        RD = 8'h5A; ATTR_LD = 1; S3H = 1; GD = 12'o0123; step();
        ATTR_LD = 0; S3H = 0; step();
        #3 nRST = 0;
        #1;
        total++; if (PIX !== 3'd7 || COLOR !== 8'h00 || OPAQUE !== 1'b0 || UNDERRUN !== 1'b0) begin
            bad++; $display("FAIL areset got pix=%0d col=%h opq=%b und=%b want 7/00/0/0", PIX, COLOR, OPAQUE, UNDERRUN);
        end
        LAYER_EN = 0;
        #3 nRST = 1;
        step();
        total++; if (PIX !== 3'd7 || OPAQUE !== 1'b0) begin bad++; $display("FAIL areset_first got pix=%0d opq=%b want 7/0", PIX, OPAQUE); end
        RD = 8'h66; ATTR_LD = 1; S3H = 1; GD = 12'o1234; step();
        ATTR_LD = 0; S3H = 0; LAYER_EN = 1;
        for (int n = 0; n < 4; n++) begin
            step();
            total++; if (PIX !== 3'(n + 1) || COLOR !== 8'h66 || UNDERRUN !== 1'b0) begin
                bad++; $display("FAIL areset_grp%0d got pix=%0d col=%h und=%b want %0d/66/0", n, PIX, COLOR, UNDERRUN, n + 1);
            end
        end
        LAYER_EN = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flip();
        test_back_to_back();
        test_fine();
        test_bypass_disable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
